// File: rtl/mv_sched_ctrl.sv
// Frame sequencer for the matrix-vector multiplier: scatters host words into the
// row/vector memories, kicks the multiplier, then streams the result memory out.
module mv_sched_ctrl #(
  parameter  int N  = 2,
  parameter  int DW = 8,
  localparam int AW = $clog2(N),
  localparam int RW = 2*DW + $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [RW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic [DW-1:0] mat_wr_data,
  output logic [AW-1:0] mat_wr_addr,
  output logic [N-1:0]  mat_we,
  output logic [DW-1:0] vec_wr_data,
  output logic [AW-1:0] vec_wr_addr,
  output logic          vec_we,
  output logic          mv_start,
  input  logic          mv_wr_en,
  input  logic [AW-1:0] mv_wr_addr,
  output logic [AW-1:0] res_rd_addr,
  input  logic [RW-1:0] res_rd_data
);

  typedef enum logic [2:0] {S_LOAD, S_GAP, S_KICK, S_RUN, S_RD, S_OUT} state_t;

  localparam logic [AW-1:0] LAST = AW'(N-1);

  state_t        state_q, state_d;
  logic [AW-1:0] row_q, row_d, col_q, col_d, idx_q, idx_d;
  logic          vphase_q, vphase_d;
  logic [N-1:0]  mat_we_q, mat_we_d;
  logic [AW-1:0] mat_wr_addr_q, mat_wr_addr_d;
  logic [DW-1:0] mat_wr_data_q, mat_wr_data_d;
  logic          vec_we_q, vec_we_d;
  logic [AW-1:0] vec_wr_addr_q, vec_wr_addr_d;
  logic [DW-1:0] vec_wr_data_q, vec_wr_data_d;
  logic          mv_start_q, mv_start_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;
  logic [AW-1:0] res_rd_addr_q, res_rd_addr_d;
  logic          accept;

  assign in_ready    = (state_q == S_LOAD);
  assign accept      = in_valid & in_ready;
  assign out_valid   = out_valid_q;
  // Read address is held through OUT, so the memory output stays stable under backpressure.
  assign out_data    = out_valid_q ? res_rd_data : '0;
  assign busy        = busy_q;
  assign mat_we      = mat_we_q;
  assign mat_wr_addr = mat_wr_addr_q;
  assign mat_wr_data = mat_wr_data_q;
  assign vec_we      = vec_we_q;
  assign vec_wr_addr = vec_wr_addr_q;
  assign vec_wr_data = vec_wr_data_q;
  assign mv_start    = mv_start_q;
  assign res_rd_addr = res_rd_addr_q;

  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    col_d         = col_q;
    idx_d         = idx_q;
    vphase_d      = vphase_q;
    mat_we_d      = '0;
    mat_wr_addr_d = mat_wr_addr_q;
    mat_wr_data_d = mat_wr_data_q;
    vec_we_d      = 1'b0;
    vec_wr_addr_d = vec_wr_addr_q;
    vec_wr_data_d = vec_wr_data_q;
    mv_start_d    = 1'b0;
    out_valid_d   = out_valid_q;
    busy_d        = busy_q;
    res_rd_addr_d = res_rd_addr_q;
    case (state_q)
      S_LOAD: if (accept) begin
        busy_d = 1'b1;
        if (!vphase_q) begin
          mat_we_d[row_q] = 1'b1;
          mat_wr_addr_d   = col_q;
          mat_wr_data_d   = in_data;
          if (col_q == LAST) begin
            col_d    = '0;
            row_d    = (row_q == LAST) ? '0 : row_q + 1'b1;
            vphase_d = (row_q == LAST);
          end else begin
            col_d = col_q + 1'b1;
          end
        end else begin
          vec_we_d      = 1'b1;
          vec_wr_addr_d = col_q;
          vec_wr_data_d = in_data;
          if (col_q == LAST) begin
            col_d    = '0;
            vphase_d = 1'b0;
            state_d  = S_GAP;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      // Spacer lets the final vector write land before the multiplier starts.
      S_GAP: begin
        state_d    = S_KICK;
        mv_start_d = 1'b1;
      end
      S_KICK: state_d = S_RUN;
      S_RUN: if (mv_wr_en && mv_wr_addr == LAST) begin
        state_d       = S_RD;
        idx_d         = '0;
        res_rd_addr_d = '0;
      end
      S_RD: begin
        state_d     = S_OUT;
        out_valid_d = 1'b1;
      end
      S_OUT: if (out_ready) begin
        out_valid_d = 1'b0;
        if (idx_q == LAST) begin
          state_d       = S_LOAD;
          busy_d        = 1'b0;
          idx_d         = '0;
          row_d         = '0;
          col_d         = '0;
          vphase_d      = 1'b0;
          res_rd_addr_d = '0;
        end else begin
          state_d       = S_RD;
          idx_d         = idx_q + 1'b1;
          res_rd_addr_d = idx_q + 1'b1;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_LOAD;
      row_q         <= '0;
      col_q         <= '0;
      idx_q         <= '0;
      vphase_q      <= 1'b0;
      mat_we_q      <= '0;
      mat_wr_addr_q <= '0;
      mat_wr_data_q <= '0;
      vec_we_q      <= 1'b0;
      vec_wr_addr_q <= '0;
      vec_wr_data_q <= '0;
      mv_start_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      res_rd_addr_q <= '0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      col_q         <= col_d;
      idx_q         <= idx_d;
      vphase_q      <= vphase_d;
      mat_we_q      <= mat_we_d;
      mat_wr_addr_q <= mat_wr_addr_d;
      mat_wr_data_q <= mat_wr_data_d;
      vec_we_q      <= vec_we_d;
      vec_wr_addr_q <= vec_wr_addr_d;
      vec_wr_data_q <= vec_wr_data_d;
      mv_start_q    <= mv_start_d;
      out_valid_q   <= out_valid_d;
      busy_q        <= busy_d;
      res_rd_addr_q <= res_rd_addr_d;
    end
  end

endmodule

// File: tb/tb_mv_sched_ctrl.sv
// Bench for mv_sched_ctrl: memories and a multiplier model around the DUT,
// table-driven frames, scoreboard queues for memory writes and results.
module tb_mv_sched_ctrl;
  localparam int N  = 2;
  localparam int DW = 8;
  localparam int AW = $clog2(N);
  localparam int RW = 2*DW + $clog2(N);
  localparam int NW = N*N + N;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [RW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          busy;
  logic [DW-1:0] mat_wr_data;
  logic [AW-1:0] mat_wr_addr;
  logic [N-1:0]  mat_we;
  logic [DW-1:0] vec_wr_data;
  logic [AW-1:0] vec_wr_addr;
  logic          vec_we;
  logic          mv_start;
  logic          mv_wr_en = 1'b0;
  logic [AW-1:0] mv_wr_addr = '0;
  logic [RW-1:0] mv_wr_data = '0;
  logic [AW-1:0] res_rd_addr;
  logic [RW-1:0] res_rd_data;

  mv_sched_ctrl #(.N(N), .DW(DW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .mat_wr_data(mat_wr_data), .mat_wr_addr(mat_wr_addr), .mat_we(mat_we),
    .vec_wr_data(vec_wr_data), .vec_wr_addr(vec_wr_addr), .vec_we(vec_we),
    .mv_start(mv_start), .mv_wr_en(mv_wr_en), .mv_wr_addr(mv_wr_addr),
    .res_rd_addr(res_rd_addr), .res_rd_data(res_rd_data)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0, start_cnt = 0, start_cyc = 0, bp_left = 0;
  bit mv_mute = 1'b0;
  logic [31:0]   wq[$];
  logic [RW-1:0] rq[$];

  logic [DW-1:0] mat_mem [N][N];
  logic [DW-1:0] vec_mem [N];
  logic [RW-1:0] res_mem [N];

  typedef struct {
    logic [NW-1:0][DW-1:0] w;
    logic [N-1:0][RW-1:0]  e;
    bit tog;
    bit junk;
    int bp;
  } rec_t;
  rec_t tbl [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] wenc(input logic v, input logic [N-1:0] we,
                                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    return 32'({v, we, a, d});
  endfunction

  function automatic logic [RW-1:0] dot(input int r);
    logic [RW-1:0] s;
    s = '0;
    for (int c = 0; c < N; c++) s = s + RW'(mat_mem[r][c]) * RW'(vec_mem[c]);
    return s;
  endfunction

  always @(posedge clk) begin
    for (int r = 0; r < N; r++) if (mat_we[r]) mat_mem[r][mat_wr_addr] <= mat_wr_data;
    if (vec_we) vec_mem[vec_wr_addr] <= vec_wr_data;
    if (mv_wr_en) res_mem[mv_wr_addr] <= mv_wr_data;
    res_rd_data <= res_mem[res_rd_addr];
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (mv_start) begin
      start_cnt++;
      start_cyc = cyc;
    end
  end

  // Every write strobe must match the next expected write exactly once.
  initial forever begin
    @(negedge clk);
    if (rst && (mat_we != '0 || vec_we)) begin
      if (wq.size() == 0) begin
        total++; bad++;
        $display("FAIL wr_extra: got mat_we=%0d vec_we=%0d want none", mat_we, vec_we);
      end else begin
        chk("wr", wenc(vec_we, mat_we, vec_we ? vec_wr_addr : mat_wr_addr,
                       vec_we ? vec_wr_data : mat_wr_data), wq.pop_front());
      end
    end
  end

  // Consumer: optional stall on the first result, otherwise accept immediately.
  initial forever begin
    @(negedge clk);
    if (!rst) out_ready = 1'b0;
    else if (out_valid) begin
      if (rq.size() == 0) begin
        total++; bad++;
        out_ready = 1'b1;
        $display("FAIL out_extra: got %0d want none", out_data);
      end else if (bp_left > 0) begin
        out_ready = 1'b0;
        bp_left--;
        chk("hold_data", 32'(out_data), 32'(rq[0]));
        chk("hold_addr", 32'(res_rd_addr), 32'd0);
      end else begin
        out_ready = 1'b1;
        chk("res_addr", 32'(res_rd_addr), 32'(N - rq.size()));
        chk("out_data", 32'(out_data), 32'(rq.pop_front()));
      end
    end else out_ready = 1'b1;
  end

  // Multiplier model: writes row 0 first, pauses, then the last row.
  initial forever begin
    @(negedge clk);
    if (mv_start && !mv_mute) begin
      repeat (2) @(negedge clk);
      for (int i = 0; i < N; i++) begin
        mv_wr_en = 1'b1; mv_wr_addr = AW'(i); mv_wr_data = dot(i);
        @(negedge clk);
        mv_wr_en = 1'b0;
        if (i < N-1) repeat (3) begin
          @(negedge clk);
          chk("stay_run", 32'({out_valid, busy, in_ready}), 32'(3'b010));
        end
      end
    end
  end

  task automatic check_idle(input string p);
    chk({p, "_busy"},   32'(busy), 32'd0);
    chk({p, "_ovalid"}, 32'(out_valid), 32'd0);
    chk({p, "_start"},  32'(mv_start), 32'd0);
    chk({p, "_mwe"},    32'(mat_we), 32'd0);
    chk({p, "_vwe"},    32'(vec_we), 32'd0);
    chk({p, "_maddr"},  32'(mat_wr_addr), 32'd0);
    chk({p, "_mdata"},  32'(mat_wr_data), 32'd0);
    chk({p, "_vaddr"},  32'(vec_wr_addr), 32'd0);
    chk({p, "_vdata"},  32'(vec_wr_data), 32'd0);
    chk({p, "_raddr"},  32'(res_rd_addr), 32'd0);
    chk({p, "_odata"},  32'(out_data), 32'd0);
    chk({p, "_iready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run_frame(input rec_t r, input bit expect_res);
    int acc, n;
    logic [N-1:0] oh;
    for (int k = 0; k < NW; k++) begin
      oh = '0;
      if (k < N*N) begin
        oh[k/N] = 1'b1;
        wq.push_back(wenc(1'b0, oh, AW'(k % N), r.w[k]));
      end else begin
        wq.push_back(wenc(1'b1, oh, AW'(k - N*N), r.w[k]));
      end
    end
    if (expect_res) for (int i = 0; i < N; i++) rq.push_back(r.e[i]);
    bp_left = r.bp;
    start_cnt = 0;
    @(posedge clk); #1;
    for (int k = 0; k < NW; k++) begin
      if (r.tog && k > 0) begin
        in_valid = 1'b0; in_data = 8'h5A;
        @(posedge clk); #1;
      end
      in_valid = 1'b1; in_data = r.w[k];
      @(negedge clk);
      chk("in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
    end
    acc = cyc - 1;
    if (r.junk) begin in_valid = 1'b1; in_data = 8'hEE; end
    else in_valid = 1'b0;
    n = 0;
    while (start_cnt == 0 && n < 20) begin @(negedge clk); n++; end
    chk("start_lat", 32'(start_cyc - acc), 32'd2);
    if (!expect_res) return;
    n = 0;
    while (rq.size() != 0 && n < 300) begin
      @(negedge clk); n++;
      if (out_valid) in_valid = 1'b0;
      if (rq.size() != 0) begin
        chk("in_ready_off", 32'(in_ready), 32'd0);
        chk("busy_on", 32'(busy), 32'd1);
      end
    end
    in_valid = 1'b0;
    if (rq.size() != 0) begin
      total++; bad++;
      $display("FAIL res_timeout: got %0d pending want 0", rq.size());
      rq.delete();
    end
    @(posedge clk); @(negedge clk);
    chk("busy_off", 32'(busy), 32'd0);
    chk("start_once", 32'(start_cnt), 32'd1);
    chk("writes_done", 32'(wq.size()), 32'd0);
  endtask

  initial begin
    rec_t abort_r;
    tbl[0] = '{w: {8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, e: {RW'(39), RW'(17)},
               tog: 1'b0, junk: 1'b0, bp: 0};
    tbl[1] = '{w: {8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255},
               e: {RW'(130050), RW'(130050)}, tog: 1'b0, junk: 1'b1, bp: 0};
    tbl[2] = '{w: {8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, e: {RW'(39), RW'(17)},
               tog: 1'b0, junk: 1'b0, bp: 5};
    tbl[3] = '{w: {8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, e: {RW'(39), RW'(17)},
               tog: 1'b1, junk: 1'b0, bp: 0};
    tbl[4] = '{w: {8'd5, 8'd4, 8'd3, 8'd0, 8'd0, 8'd2}, e: {RW'(15), RW'(8)},
               tog: 1'b1, junk: 1'b1, bp: 2};
    abort_r = '{w: {8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3}, e: {RW'(0), RW'(0)},
                tog: 1'b0, junk: 1'b0, bp: 0};

    #1 rst = 1'b0;
    #1 check_idle("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    for (int i = 0; i < 5; i++) run_frame(tbl[i], 1'b1);

    // Abort a frame while the multiplier is running, then run a fresh one.
    mv_mute = 1'b1;
    run_frame(abort_r, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 check_idle("midrst");
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    mv_mute = 1'b0;
    wq.delete();
    abort_r = '{w: {8'd9, 8'd7, 8'd0, 8'd1, 8'd1, 8'd0}, e: {RW'(7), RW'(9)},
                tog: 1'b0, junk: 1'b0, bp: 0};
    run_frame(abort_r, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
